// File: rtl/mannix_mem_pkg.sv
// Shared types and constants for the memory read server: line geometry,
// FSM state encoding and the latched request record.
package mannix_mem_pkg;

  localparam int MEM_WORD_WIDTH = 8;
  localparam int MEM_NUM_WORDS  = 32;
  localparam int MEM_ADDR_WIDTH = 19;
  localparam int LINE_BYTES     = MEM_NUM_WORDS * MEM_WORD_WIDTH / 8;
  localparam int LINE_OFS_W     = $clog2(LINE_BYTES);
  localparam int LINE_ADDR_W    = MEM_ADDR_WIDTH - LINE_OFS_W;
  localparam int LINE_CNT_W     = MEM_ADDR_WIDTH + 1;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } mem_rd_state_e;

  typedef struct packed {
    logic [LINE_ADDR_W-1:0] line_addr;
    logic [LINE_CNT_W-1:0]  line_cnt;
    logic [LINE_OFS_W-1:0]  last_valid;
  } mem_rd_req_t;

  // Line count uses one extra bit so a maximum-size request cannot overflow.
  function automatic mem_rd_req_t mem_rd_decode(
    input logic [MEM_ADDR_WIDTH-1:0] start_addr,
    input logic [MEM_ADDR_WIDTH-1:0] size_bytes
  );
    mem_rd_req_t           req;
    logic [LINE_CNT_W-1:0] rounded;
    rounded        = {1'b0, size_bytes} + LINE_CNT_W'(LINE_BYTES - 1);
    req.line_addr  = start_addr[MEM_ADDR_WIDTH-1:LINE_OFS_W];
    req.line_cnt   = LINE_CNT_W'(rounded >> LINE_OFS_W);
    req.last_valid = LINE_OFS_W'(size_bytes - MEM_ADDR_WIDTH'(1));
    return req;
  endfunction

endpackage

// File: rtl/mem_read_server.sv
// Streams consecutive SRAM lines back to a read client, one per cycle.
// Optional back-to-back request queueing is enabled by defining MEM_RD_PEND_EN.
module mem_read_server
  import mannix_mem_pkg::*;
#(
  parameter  int WORD_WIDTH        = MEM_WORD_WIDTH,
  parameter  int NUM_WORDS_IN_LINE = MEM_NUM_WORDS,
  parameter  int ADDR_WIDTH        = MEM_ADDR_WIDTH,
  localparam int LB                = NUM_WORDS_IN_LINE * WORD_WIDTH / 8,
  localparam int OFS_W             = $clog2(LB),
  localparam int DATA_W            = NUM_WORDS_IN_LINE * WORD_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mem_req,
  input  logic [ADDR_WIDTH-1:0]       mem_start_addr,
  input  logic [ADDR_WIDTH-1:0]       mem_size_bytes,
  output logic                        mem_valid,
  output logic                        last,
  output logic [DATA_W-1:0]           mem_data,
  output logic [OFS_W-1:0]            mem_last_valid,
  output logic                        sram_cs,
  output logic [ADDR_WIDTH-OFS_W-1:0] sram_addr,
  input  logic [DATA_W-1:0]           sram_rdata
);

  mem_rd_state_e state, state_nxt;
  mem_rd_req_t   cur, cur_nxt;
  logic          req_ok;
  logic          final_rd;
  logic          rd_issued, rd_last;

`ifdef MEM_RD_PEND_EN
  mem_rd_req_t           pend, pend_nxt;
  logic                  pend_vld, pend_vld_nxt;
  logic [LINE_OFS_W-1:0] lv_tail;
`endif

  assign req_ok   = mem_req && (mem_size_bytes != {ADDR_WIDTH{1'b0}});
  assign final_rd = (state == READ) && (cur.line_cnt == LINE_CNT_W'(1));

  // Next-state and next-request computation.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
`ifdef MEM_RD_PEND_EN
    pend_nxt     = pend;
    pend_vld_nxt = pend_vld;
`endif
    case (state)
      IDLE: begin
        if (req_ok) begin
          cur_nxt   = mem_rd_decode(mem_start_addr, mem_size_bytes);
          state_nxt = READ;
        end else begin
          state_nxt = IDLE;
        end
      end
      READ: begin
        cur_nxt.line_addr = cur.line_addr + LINE_ADDR_W'(1);
        cur_nxt.line_cnt  = cur.line_cnt - LINE_CNT_W'(1);
        if (final_rd) begin
`ifdef MEM_RD_PEND_EN
          // Chain straight into the queued (or just-arriving) request.
          if (pend_vld) begin
            cur_nxt      = pend;
            pend_vld_nxt = 1'b0;
          end else if (req_ok) begin
            cur_nxt = mem_rd_decode(mem_start_addr, mem_size_bytes);
          end else begin
            state_nxt = IDLE;
          end
`else
          state_nxt = IDLE;
`endif
        end else begin
`ifdef MEM_RD_PEND_EN
          if (req_ok && !pend_vld) begin
            pend_nxt     = mem_rd_decode(mem_start_addr, mem_size_bytes);
            pend_vld_nxt = 1'b1;
          end else begin
            pend_vld_nxt = pend_vld;
          end
`else
          state_nxt = READ;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur   <= {$bits(mem_rd_req_t){1'b0}};
`ifdef MEM_RD_PEND_EN
      pend     <= {$bits(mem_rd_req_t){1'b0}};
      pend_vld <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
`ifdef MEM_RD_PEND_EN
      pend     <= pend_nxt;
      pend_vld <= pend_vld_nxt;
`endif
    end
  end

  // Output stage aligned with the SRAM's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_issued <= 1'b0;
      rd_last   <= 1'b0;
`ifdef MEM_RD_PEND_EN
      lv_tail   <= {LINE_OFS_W{1'b0}};
`endif
    end else begin
      rd_issued <= (state == READ);
      rd_last   <= final_rd;
`ifdef MEM_RD_PEND_EN
      lv_tail   <= cur.last_valid;
`endif
    end
  end

  assign sram_cs   = (state == READ);
  assign sram_addr = cur.line_addr;
  assign mem_valid = rd_issued;
  assign last      = rd_last;
  assign mem_data  = rd_issued ? sram_rdata : {DATA_W{1'b0}};

`ifdef MEM_RD_PEND_EN
  // During a final line the active record may already belong to the next transfer.
  assign mem_last_valid = rd_last ? lv_tail : cur.last_valid;
`else
  assign mem_last_valid = cur.last_valid;
`endif

endmodule

// File: tb/tb_mem_read_server.sv
// Randomized self-checking bench for mem_read_server with a schedule-level reference model.
module tb_mem_read_server;

  localparam int AW  = 19;
  localparam int DW  = 256;
  localparam int LBY = 32;
  localparam int LAW = 14;
  localparam int NLINES = 16384;
  localparam int HMAX = 256;
`ifdef MEM_RD_PEND_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mem_req = 1'b0;
  logic [AW-1:0]  mem_start_addr = '0;
  logic [AW-1:0]  mem_size_bytes = '0;
  logic           mem_valid, last, sram_cs;
  logic [DW-1:0]  mem_data;
  logic [4:0]     mem_last_valid;
  logic [LAW-1:0] sram_addr;
  logic [DW-1:0]  sram_rdata = '0;

  int n_checks = 0;
  int n_fail = 0;

  int            req_n;
  logic [AW-1:0] req_addr[3];
  int            req_size[3];
  int            req_cyc[3];

  bit             exp_cs[HMAX];
  logic [LAW-1:0] exp_addr[HMAX];
  bit             exp_last[HMAX];
  int             exp_lv[HMAX];

  mem_read_server dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_start_addr(mem_start_addr),
    .mem_size_bytes(mem_size_bytes), .mem_valid(mem_valid), .last(last),
    .mem_data(mem_data), .mem_last_valid(mem_last_valid), .sram_cs(sram_cs),
    .sram_addr(sram_addr), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] line_pattern(input logic [LAW-1:0] a);
    logic [DW-1:0] d;
    logic [31:0]   h;
    h = ({18'h0, a} * 32'h9E3779B1) ^ 32'h5A5A_0000;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = h + 32'(i * 32'h0101_0101);
    return d;
  endfunction

  // SRAM with one-cycle read latency
  always @(posedge clk) if (sram_cs) sram_rdata <= line_pattern(sram_addr);

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_valid"}, DW'(mem_valid), '0);
    check_val({tag, "_last"}, DW'(last), '0);
    check_val({tag, "_data"}, mem_data, '0);
    check_val({tag, "_lv"}, DW'(mem_last_valid), '0);
    check_val({tag, "_cs"}, DW'(sram_cs), '0);
    check_val({tag, "_addr"}, DW'(sram_addr), '0);
  endtask

  // Builds the expected read schedule from the request list, then drives and checks it.
  task automatic run_seq(input string tag);
    int last_read = -1;
    int last_start = -1;
    int horizon;
    for (int i = 0; i < HMAX; i++) begin
      exp_cs[i] = 1'b0; exp_addr[i] = '0; exp_last[i] = 1'b0; exp_lv[i] = 0;
    end
    for (int r = 0; r < req_n; r++) begin
      int c, start, nl, line;
      c = req_cyc[r];
      if (req_size[r] == 0) continue;
      if (c > last_read) start = c + 1;
      else if (PEND && c >= last_start) start = last_read + 1;
      else continue;
      nl   = (req_size[r] + LBY - 1) / LBY;
      line = int'(req_addr[r]) / LBY;
      for (int j = 0; j < nl; j++) begin
        exp_cs[start + j]   = 1'b1;
        exp_addr[start + j] = LAW'((line + j) % NLINES);
        exp_last[start + j] = (j == nl - 1);
        exp_lv[start + j]   = (req_size[r] - 1) % LBY;
      end
      last_read  = start + nl - 1;
      last_start = start;
    end
    horizon = last_read + 3;
    if (req_cyc[req_n-1] + 3 > horizon) horizon = req_cyc[req_n-1] + 3;
    for (int cyc = 0; cyc <= horizon; cyc++) begin
      if (cyc > 0) begin
        check_val({tag, "_cs"}, DW'(sram_cs), DW'(exp_cs[cyc]));
        if (exp_cs[cyc]) check_val({tag, "_addr"}, DW'(sram_addr), DW'(exp_addr[cyc]));
        check_val({tag, "_valid"}, DW'(mem_valid), DW'(exp_cs[cyc-1]));
        check_val({tag, "_last"}, DW'(last), DW'(exp_last[cyc-1]));
        check_val({tag, "_data"}, mem_data, exp_cs[cyc-1] ? line_pattern(exp_addr[cyc-1]) : '0);
        if (exp_last[cyc-1]) check_val({tag, "_lv"}, DW'(mem_last_valid), DW'(exp_lv[cyc-1]));
      end
      mem_req = 1'b0;
      for (int r = 0; r < req_n; r++) begin
        if (req_cyc[r] == cyc) begin
          mem_req        = 1'b1;
          mem_start_addr = req_addr[r];
          mem_size_bytes = AW'(req_size[r]);
        end
      end
      @(negedge clk);
    end
    mem_req = 1'b0;
  endtask

  task automatic one_req(input string tag, input logic [AW-1:0] a, input int s);
    req_n = 1; req_addr[0] = a; req_size[0] = s; req_cyc[0] = 0;
    run_seq(tag);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    one_req("two_lines", 19'h00040, 64);
    one_req("one_byte", 19'h0001F, 1);
    one_req("size100", 19'h00000, 100);
    one_req("size0", 19'h00100, 0);
    one_req("wrap", 19'h7FFE0, 96);

    req_n = 2;
    req_addr[0] = 19'h00200; req_size[0] = 128; req_cyc[0] = 0;
    req_addr[1] = 19'h01000; req_size[1] = 64;  req_cyc[1] = 1;
    run_seq("overlap");

    req_n = 3;
    req_addr[0] = 19'h00400; req_size[0] = 128; req_cyc[0] = 0;
    req_addr[1] = 19'h02000; req_size[1] = 64;  req_cyc[1] = 1;
    req_addr[2] = 19'h03000; req_size[2] = 32;  req_cyc[2] = 2;
    run_seq("pend_full");

    // Reset asserted mid-way through an 8-line transfer.
    mem_req = 1'b1; mem_start_addr = 19'h00800; mem_size_bytes = 19'd256;
    @(negedge clk);
    mem_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("abort_pre_valid", DW'(mem_valid), DW'(1'b1));
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("post_abort_valid", DW'(mem_valid), '0);
      check_val("post_abort_cs", DW'(sram_cs), '0);
    end

    for (int t = 0; t < 25; t++) begin
      int c;
      req_n = int'($urandom_range(1, 3));
      c = 0;
      for (int r = 0; r < req_n; r++) begin
        req_cyc[r]  = c;
        c           = c + int'($urandom_range(1, 6));
        req_addr[r] = ($urandom_range(0, 3) == 0) ? AW'(19'h7FF00 + $urandom_range(0, 255))
                                                  : AW'($urandom);
        req_size[r] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 600));
      end
      run_seq("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
